// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder: FSM state encoding,
// RISC-V load/store size codes (funct3) and the default base address.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    function automatic logic size_legal(input logic [2:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
               (size == SZ_BU) || (size == SZ_HU);
    endfunction

    function automatic logic size_unsigned(input logic [2:0] size);
        return (size == SZ_BU) || (size == SZ_HU);
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Little-endian byte-lane steering: extracts and extends load values, merges
// store data into an existing word, and flags misaligned half/word accesses.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [2:0]  size,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        half_sel = word[{lane[1], 4'b0000} +: 16];

        load_data = 32'd0;
        case (size)
            SZ_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    load_data = {{16{half_sel[15]}}, half_sel};
            SZ_W:    load_data = word;
            SZ_BU:   load_data = {24'd0, byte_sel};
            SZ_HU:   load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase
    end

    // Only the addressed lanes change; all others keep the old word's bytes.
    always_comb begin
        store_word = word;
        case (size)
            SZ_B:    store_word[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_H:    store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            SZ_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SZ_H, SZ_HU: misaligned = lane[0];
            SZ_W:        misaligned = (lane != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the core's data port: accepts one load/store at a time, waits a
// fixed number of cycles, then answers with a one-cycle mem_ready strobe.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_write_data,
    input  logic [2:0]  mem_size,
    output logic [31:0] d_read_data,
    output logic        mem_ready,
    output logic        mem_busy,
    output logic        mem_error
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

    // Handshake: mem_read/mem_write act as a request level sampled only in IDLE;
    // the requester holds it stable until mem_ready, which pulses for exactly one
    // cycle (qualified by mem_error). A level still high in the cycle after
    // mem_ready is a new request.

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        load_req, enter_resp;

    logic [31:0] addr_q, wdata_q;
    logic [2:0]  size_q;
    logic        rd_q, wr_q, err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_size;
    logic        cur_rd, cur_wr;
    logic [31:0] offset;
    logic        in_range;
    logic [IDX_W-1:0] idx;
    logic [31:0] rd_word, load_data, store_word;
    logic        misaligned, req_err;

    // While IDLE the live inputs describe the request; afterwards the latched copy.
    assign cur_addr  = (state == S_IDLE) ? d_address    : addr_q;
    assign cur_wdata = (state == S_IDLE) ? d_write_data : wdata_q;
    assign cur_size  = (state == S_IDLE) ? mem_size     : size_q;
    assign cur_rd    = (state == S_IDLE) ? mem_read     : rd_q;
    assign cur_wr    = (state == S_IDLE) ? mem_write    : wr_q;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign offset   = cur_addr - BASE_ADDR;
    assign in_range = (offset < SPAN_BYTES);
    assign idx      = offset[IDX_W+1:2];
    assign rd_word  = mem[idx];

    load_store_align u_align (
        .lane       (cur_addr[1:0]),
        .size       (cur_size),
        .word       (rd_word),
        .wdata      (cur_wdata),
        .load_data  (load_data),
        .store_word (store_word),
        .misaligned (misaligned)
    );

    assign req_err = (cur_rd & cur_wr)
                   | !size_legal(cur_size)
                   | (cur_wr & size_unsigned(cur_size))
                   | misaligned
                   | !in_range;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_req   = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    load_req = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_next = S_WAIT;
                        cnt_next   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_next = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            size_q      <= 3'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            d_read_data <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (load_req) begin
                addr_q  <= d_address;
                wdata_q <= d_write_data;
                size_q  <= mem_size;
                rd_q    <= mem_read;
                wr_q    <= mem_write;
            end
            if (enter_resp) begin
                err_q       <= req_err;
                d_read_data <= (req_err || !cur_rd) ? 32'd0 : load_data;
            end
        end
    end

    // Store commit on the RESP edge; reset on the same edge cancels it.
    always_ff @(posedge clk) begin
        if (!rst && (state == S_RESP) && wr_q && !err_q) begin
            mem[idx] <= store_word;
        end
    end

    assign mem_ready = (state == S_RESP);
    assign mem_busy  = (state != S_IDLE);
    assign mem_error = mem_ready & err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: default instance (2 wait states) plus a
// zero-wait-state instance for back-to-back timing.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] d_address = 32'd0, d_write_data = 32'd0;
    logic [2:0]  mem_size = SZ_W;
    logic [31:0] d_read_data;
    logic        mem_ready, mem_busy, mem_error;

    logic        z_read = 1'b0, z_write = 1'b0;
    logic [31:0] z_addr = 32'd0, z_wdata = 32'd0;
    logic [2:0]  z_size = SZ_W;
    logic [31:0] z_rdata;
    logic        z_ready, z_busy, z_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .d_address(d_address), .d_write_data(d_write_data), .mem_size(mem_size),
        .d_read_data(d_read_data), .mem_ready(mem_ready), .mem_busy(mem_busy),
        .mem_error(mem_error)
    );

    data_mem_responder #(.WAIT_STATES(0)) dut_z (
        .clk(clk), .rst(rst), .mem_read(z_read), .mem_write(z_write),
        .d_address(z_addr), .d_write_data(z_wdata), .mem_size(z_size),
        .d_read_data(z_rdata), .mem_ready(z_ready), .mem_busy(z_busy),
        .mem_error(z_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one request at a negedge and hold it until mem_ready (bounded).
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] size,
                          output int lat, output logic [31:0] data, output logic err,
                          output logic busy_mid);
        @(negedge clk);
        mem_read = rd; mem_write = wr; d_address = addr; d_write_data = wdata; mem_size = size;
        lat = -1; data = 'x; err = 1'bx; busy_mid = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) busy_mid = mem_busy;
            if (mem_ready) begin
                lat = k; data = d_read_data; err = mem_error;
                break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, input logic [31:0] exp_data,
                          input logic exp_err);
        int lat;
        logic [31:0] data;
        logic err, busy_mid;
        do_req(rd, wr, addr, wdata, size, lat, data, err, busy_mid);
        check({tag, "_lat"},  32'(lat), 32'd3);
        check({tag, "_data"}, data, exp_data);
        check({tag, "_err"},  {31'd0, err}, {31'd0, exp_err});
        check({tag, "_busy"}, {31'd0, busy_mid}, 32'd1);
    endtask

    task automatic z_store(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        z_write = 1'b1; z_addr = addr; z_wdata = data; z_size = SZ_W;
        @(negedge clk);
        check("z_sw_ready", {31'd0, z_ready}, 32'd1);
        z_write = 1'b0;
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_busy",  {31'd0, mem_busy},  32'd0);
        check("rst_error", {31'd0, mem_error}, 32'd0);
        check("rst_data",  d_read_data,        32'd0);
        rst = 1'b0;

        access("sw_word", 1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, SZ_W, 32'h0, 1'b0);
        @(negedge clk);
        check("busy_after_ready", {31'd0, mem_busy}, 32'd0);
        access("lw_word", 1'b1, 1'b0, 32'h1001_0004, 32'h0, SZ_W,  32'hDEAD_BEEF, 1'b0);
        access("lb",      1'b1, 1'b0, 32'h1001_0007, 32'h0, SZ_B,  32'hFFFF_FFDE, 1'b0);
        access("lbu",     1'b1, 1'b0, 32'h1001_0007, 32'h0, SZ_BU, 32'h0000_00DE, 1'b0);
        access("lh",      1'b1, 1'b0, 32'h1001_0006, 32'h0, SZ_H,  32'hFFFF_DEAD, 1'b0);
        access("lhu",     1'b1, 1'b0, 32'h1001_0006, 32'h0, SZ_HU, 32'h0000_DEAD, 1'b0);

        access("sb_lane1", 1'b0, 1'b1, 32'h1001_0005, 32'h0000_0012, SZ_B, 32'h0, 1'b0);
        access("lw_merge", 1'b1, 1'b0, 32'h1001_0004, 32'h0, SZ_W, 32'hDEAD_12EF, 1'b0);
        access("lb_lane1", 1'b1, 1'b0, 32'h1001_0005, 32'h0, SZ_B, 32'h0000_0012, 1'b0);

        access("lw_misal",  1'b1, 1'b0, 32'h1001_0002, 32'h0, SZ_W, 32'h0, 1'b1);
        access("lh_misal",  1'b1, 1'b0, 32'h1001_0005, 32'h0, SZ_H, 32'h0, 1'b1);
        access("lw_oor_hi", 1'b1, 1'b0, 32'h1001_1000, 32'h0, SZ_W, 32'h0, 1'b1);
        access("lw_oor_lo", 1'b1, 1'b0, 32'h1000_FFFC, 32'h0, SZ_W, 32'h0, 1'b1);
        access("lw_badsz",  1'b1, 1'b0, 32'h1001_0004, 32'h0, 3'b011, 32'h0, 1'b1);
        access("sw_both",   1'b1, 1'b1, 32'h1001_0004, 32'h1111_1111, SZ_W, 32'h0, 1'b1);
        access("sbu_store", 1'b0, 1'b1, 32'h1001_0004, 32'h0000_0022, SZ_BU, 32'h0, 1'b1);
        access("lw_unchg",  1'b1, 1'b0, 32'h1001_0004, 32'h0, SZ_W, 32'hDEAD_12EF, 1'b0);

        access("sw_last", 1'b0, 1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, SZ_W, 32'h0, 1'b0);
        access("lw_last", 1'b1, 1'b0, 32'h1001_0FFC, 32'h0, SZ_W, 32'hCAFE_F00D, 1'b0);

        // Store abandoned by reset during WAIT.
        @(negedge clk);
        mem_write = 1'b1; d_address = 32'h1001_0004; d_write_data = 32'h0; mem_size = SZ_W;
        @(negedge clk);
        check("rst_mid_busy_wait", {31'd0, mem_busy}, 32'd1);
        rst = 1'b1; mem_write = 1'b0;
        @(negedge clk);
        check("rst_mid_busy",  {31'd0, mem_busy},  32'd0);
        check("rst_mid_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_mid_data",  d_read_data,        32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_ready) seen++;
        end
        check("rst_mid_no_ready", 32'(seen), 32'd0);
        access("lw_after_rst", 1'b1, 1'b0, 32'h1001_0004, 32'h0, SZ_W, 32'hDEAD_12EF, 1'b0);

        // Zero wait states: held read level gives a response every other cycle.
        z_store(32'h1001_0000, 32'hAAAA_5555);
        z_store(32'h1001_0004, 32'h1234_5678);
        @(negedge clk);
        z_read = 1'b1; z_addr = 32'h1001_0000; z_size = SZ_W;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("z_ready_c%0d", k), {31'd0, z_ready}, {31'd0, k[0]});
            if (k[0]) begin
                check($sformatf("z_data_c%0d", k), z_rdata,
                      (k == 3) ? 32'h1234_5678 : 32'hAAAA_5555);
                check($sformatf("z_err_c%0d", k), {31'd0, z_error}, 32'd0);
            end
            if (k == 1) z_addr = 32'h1001_0004;
            if (k == 3) z_addr = 32'h1001_0000;
            if (k == 5) z_read = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
